random_checker: RTL and testbench

RANDOM_CHECKER -- requirements
Module: random_checker

---
 rtl/random_pkg.sv | 23 ++
 rtl/random_checker_if.sv | 21 ++
 rtl/random_checker.sv | 114 +++++++++++
 tb/tb_random_checker.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/random_pkg.sv
// Shared constants for the PRBS checker: LFSR geometry, generator taps and seed, FSM states.
package random_pkg;

    localparam int LFSR_W = 13;
    localparam int TAP_0  = 12;
    localparam int TAP_1  = 4;
    localparam int TAP_2  = 3;
    localparam int TAP_3  = 1;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 13'h1245;

    // Consistent samples needed before the window is trusted.
    localparam logic [2:0] HUNT_LEN = 3'd6;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[TAP_0] ^ s[TAP_1] ^ s[TAP_2] ^ s[TAP_3]};
    endfunction

endpackage

// File: rtl/random_checker_if.sv
// Stream and status bundle between a PRBS source (master) and the checker (slave).
interface random_checker_if #(
    parameter int CNT_W = 16
);
    logic             ena;
    logic [7:0]       stream;
    logic             locked;
    logic             error;
    logic             stuck;
    logic [CNT_W-1:0] err_count;

    modport master (
        output ena, stream,
        input  locked, error, stuck, err_count
    );

    modport slave (
        input  ena, stream,
        output locked, error, stuck, err_count
    );
endinterface

// File: rtl/random_checker.sv
// PRBS checker: hunts for six consistent bytes, then flywheels and counts mismatches.
// Define RANDOM_CHECKER_STATS_EN to build the saturating err_count counter.
module random_checker
    import random_pkg::*;
#(
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input logic             clk,
    input logic             rst,
    random_checker_if.slave bus
);

    localparam int MISS_W = $clog2(LOSS_THRESH + 1);

    state_t            state, state_next;
    logic [LFSR_W-1:0] win, win_next, pred;
    logic [2:0]        hunt_cnt, hunt_next;
    logic [MISS_W-1:0] miss_cnt, miss_next;
    logic              error_q, error_next;
    logic              stuck_q, stuck_next;

    // win trails the generator by two shifts, so its successor predicts the next byte.
    assign pred = lfsr_next(win);

    always_comb begin
        // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
        state_next = state;
        win_next   = win;
        hunt_next  = hunt_cnt;
        miss_next  = miss_cnt;
        error_next = 1'b0;
        stuck_next = stuck_q;

        if (bus.ena) begin
            case (state)
                HUNT: begin
                    win_next = {win[11:7], bus.stream};
                    if (hunt_cnt == '0 || bus.stream[7:1] == win[6:0]) begin
                        hunt_next = hunt_cnt + 3'd1;
                    end else begin
                        hunt_next = 3'd1;
                    end
                    if (hunt_next == HUNT_LEN) begin
                        hunt_next = '0;
                        if (win_next == '0) begin
                            stuck_next = 1'b1;
                        end else begin
                            state_next = LOCKED;
                            miss_next  = '0;
                        end
                    end
                end
                LOCKED: begin
                    win_next = pred;
                    if (bus.stream != pred[7:0]) begin
                        error_next = 1'b1;
                        if (miss_cnt == MISS_W'(LOSS_THRESH - 1)) begin
                            state_next = HUNT;
                            hunt_next  = '0;
                            miss_next  = '0;
                        end else begin
                            miss_next = miss_cnt + 1'b1;
                        end
                    end else begin
                        miss_next = '0;
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            win      <= '0;
            hunt_cnt <= '0;
            miss_cnt <= '0;
            error_q  <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            state    <= state_next;
            win      <= win_next;
            hunt_cnt <= hunt_next;
            miss_cnt <= miss_next;
            error_q  <= error_next;
            stuck_q  <= stuck_next;
        end
    end

    assign bus.locked = (state == LOCKED);
    assign bus.error  = error_q;
    assign bus.stuck  = stuck_q;

`ifdef RANDOM_CHECKER_STATS_EN
    logic [CNT_W-1:0] err_count;

    // Saturates at all-ones so a long bad run never reads back as a small count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (error_next && err_count != '1) begin
            err_count <= err_count + 1'b1;
        end
    end

    assign bus.err_count = err_count;
`else
    assign bus.err_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_random_checker.sv
// Directed bench for random_checker: lock, single error, loss of lock, stuck, ena gaps, reset mid-lock.
module tb_random_checker;
    import random_pkg::*;

    localparam int CNT_W = 16;
`ifdef RANDOM_CHECKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [12:0] g;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    random_checker_if #(.CNT_W(CNT_W)) bus ();

    random_checker #(.LOSS_THRESH(4), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [12:0] gen_next(input logic [12:0] s);
        logic fb;
        fb = s[12] ^ s[4] ^ s[3] ^ s[1];
        return {s[11:0], fb};
    endfunction

    function automatic logic [CNT_W-1:0] exp_cnt(input int n);
        return STATS ? CNT_W'(n) : '0;
    endfunction

    task automatic step(input logic e, input logic [7:0] s);
        bus.ena    = e;
        bus.stream = s;
        @(posedge clk);
        #1;
    endtask

    task automatic gen_step(input logic [7:0] flip);
        step(1'b1, g[9:2] ^ flip);
        g = gen_next(g);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.ena = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.ena    = 1'b0;
        bus.stream = 8'h00;
        #2;
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked got=%b exp=0", bus.locked); end
        n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL reset_error got=%b exp=0", bus.error); end
        n_cmp++; if (bus.stuck !== 1'b0) begin n_bad++; $display("FAIL reset_stuck got=%b exp=0", bus.stuck); end
        n_cmp++; if (bus.err_count !== '0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", bus.err_count); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 8'hA5);
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL idle_locked got=%b exp=0", bus.locked); end
    endtask

    task automatic test_lock();
        int errs;
        g = LFSR_SEED;
        for (int i = 1; i <= 6; i++) begin
            gen_step(8'h00);
            n_cmp++; if (bus.locked !== (i == 6)) begin n_bad++; $display("FAIL lock_point sample=%0d got=%b exp=%b", i, bus.locked, i == 6); end
        end
        errs = 0;
        for (int i = 0; i < 10000; i++) begin
            gen_step(8'h00);
            if (bus.error !== 1'b0) errs++;
        end
        n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL clean_errors got=%0d exp=0", errs); end
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL clean_locked got=%b exp=1", bus.locked); end
        n_cmp++; if (bus.err_count !== '0) begin n_bad++; $display("FAIL clean_count got=%0d exp=0", bus.err_count); end
    endtask

    task automatic test_single_error();
        gen_step(8'h01);
        n_cmp++; if (bus.error !== 1'b1) begin n_bad++; $display("FAIL single_error got=%b exp=1", bus.error); end
        n_cmp++; if (bus.err_count !== exp_cnt(1)) begin n_bad++; $display("FAIL single_count got=%0d exp=%0d", bus.err_count, exp_cnt(1)); end
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL single_locked got=%b exp=1", bus.locked); end
        gen_step(8'h00);
        n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL single_pulse_width got=%b exp=0", bus.error); end
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL single_still_locked got=%b exp=1", bus.locked); end
    endtask

    task automatic test_reset_mid_lock();
        gen_step(8'h01);
        gen_step(8'h00);
        gen_step(8'h80);
        gen_step(8'h00);
        n_cmp++; if (bus.err_count !== exp_cnt(3)) begin n_bad++; $display("FAIL pre_reset_count got=%0d exp=%0d", bus.err_count, exp_cnt(3)); end
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL pre_reset_locked got=%b exp=1", bus.locked); end
        gen_step(8'h01);
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL async_locked got=%b exp=0", bus.locked); end
        n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL async_error got=%b exp=0", bus.error); end
        n_cmp++; if (bus.err_count !== '0) begin n_bad++; $display("FAIL async_count got=%0d exp=0", bus.err_count); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            gen_step(8'h00);
            n_cmp++; if (bus.locked !== (i == 6)) begin n_bad++; $display("FAIL relock_reset sample=%0d got=%b exp=%b", i, bus.locked, i == 6); end
        end
    endtask

    task automatic test_loss();
        for (int i = 1; i <= 4; i++) begin
            gen_step(8'h01);
            n_cmp++; if (bus.error !== 1'b1) begin n_bad++; $display("FAIL loss_error n=%0d got=%b exp=1", i, bus.error); end
            n_cmp++; if (bus.locked !== (i < 4)) begin n_bad++; $display("FAIL loss_locked n=%0d got=%b exp=%b", i, bus.locked, i < 4); end
            n_cmp++; if (bus.err_count !== exp_cnt(i)) begin n_bad++; $display("FAIL loss_count n=%0d got=%0d exp=%0d", i, bus.err_count, exp_cnt(i)); end
        end
        for (int i = 1; i <= 6; i++) begin
            gen_step(8'h00);
            if (i == 1) begin
                n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL loss_error_drop got=%b exp=0", bus.error); end
            end
            n_cmp++; if (bus.locked !== (i == 6)) begin n_bad++; $display("FAIL relock_loss sample=%0d got=%b exp=%b", i, bus.locked, i == 6); end
        end
    endtask

    task automatic test_stuck();
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 8'h00);
            n_cmp++; if (bus.stuck !== (i == 6)) begin n_bad++; $display("FAIL stuck_point sample=%0d got=%b exp=%b", i, bus.stuck, i == 6); end
            n_cmp++; if (bus.locked !== 1'b0) begin n_bad++; $display("FAIL stuck_locked sample=%0d got=%b exp=0", i, bus.locked); end
        end
        g = LFSR_SEED;
        for (int i = 1; i <= 6; i++) gen_step(8'h00);
        n_cmp++; if (bus.locked !== 1'b1) begin n_bad++; $display("FAIL stuck_relock got=%b exp=1", bus.locked); end
        n_cmp++; if (bus.stuck !== 1'b1) begin n_bad++; $display("FAIL stuck_sticky got=%b exp=1", bus.stuck); end
    endtask

    task automatic test_ena_gaps();
        int n;
        do_reset();
        g = LFSR_SEED;
        n = 0;
        for (int c = 0; c < 80; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                gen_step(8'h00);
                n++;
            end else begin
                step(1'b0, 8'($urandom));
            end
            n_cmp++; if (bus.locked !== (n >= 6)) begin n_bad++; $display("FAIL gap_locked cycle=%0d samples=%0d got=%b exp=%b", c, n, bus.locked, n >= 6); end
            n_cmp++; if (bus.error !== 1'b0) begin n_bad++; $display("FAIL gap_error cycle=%0d got=%b exp=0", c, bus.error); end
        end
        n_cmp++; if (n < 6) begin n_bad++; $display("FAIL gap_sample_budget got=%0d exp>=6", n); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_single_error();
        test_reset_mid_lock();
        test_loss();
        test_stuck();
        test_ena_gaps();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
